// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Shares the register-file write port (we3/ad3/wd3) between the
//             ALU and load writeback channels, each with a one-entry slot.
//             Optional macro WB_BYPASS_EN enables the zero-latency bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              we3,
    output logic [ADDR_W-1:0] ad3,
    output logic [DATA_W-1:0] wd3,
    output logic [NREG-1:0]   busy,
    output logic [15:0]       conflict_cnt
);

    logic              r_alu_v;
    logic [ADDR_W-1:0] r_alu_addr;
    logic [DATA_W-1:0] r_alu_data;
    logic              r_mem_v;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_rr;
    logic              r_age;
    logic [15:0]       r_conflict_cnt;

    logic              w_both;
    logic              w_same;
    logic              w_contended;
    logic              w_grant_alu;
    logic              w_grant_mem;
    logic              w_alu_load;
    logic              w_mem_load;
    logic              w_alu_stay;
    logic              w_mem_stay;
    logic [NREG-1:0]   w_busy;

    assign w_both      = r_alu_v && r_mem_v;
    assign w_same      = (r_alu_addr == r_mem_addr);
    assign w_contended = w_both && !w_same;

    // Same-address pairs go oldest-first so writes to one register stay ordered.
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (w_both) begin
            if (w_same) begin
                w_grant_mem = r_age;
                w_grant_alu = !r_age;
            end else begin
                w_grant_mem = r_rr;
                w_grant_alu = !r_rr;
            end
        end else if (r_alu_v) begin
            w_grant_alu = 1'b1;
        end else if (r_mem_v) begin
            w_grant_mem = 1'b1;
        end
    end

    assign alu_ready = !rst && (!r_alu_v || w_grant_alu);
    assign mem_ready = !rst && (!r_mem_v || w_grant_mem);

`ifdef WB_BYPASS_EN
    logic w_byp_alu;
    logic w_byp_mem;

    // Bypass only when the port is otherwise idle and exactly one request shows up.
    assign w_byp_alu = !rst && !r_alu_v && !r_mem_v && alu_valid && !mem_valid
                       && (alu_addr != '0);
    assign w_byp_mem = !rst && !r_alu_v && !r_mem_v && mem_valid && !alu_valid
                       && (mem_addr != '0);
    assign w_alu_load = alu_valid && alu_ready && (alu_addr != '0) && !w_byp_alu;
    assign w_mem_load = mem_valid && mem_ready && (mem_addr != '0) && !w_byp_mem;
`else
    assign w_alu_load = alu_valid && alu_ready && (alu_addr != '0);
    assign w_mem_load = mem_valid && mem_ready && (mem_addr != '0);
`endif

    assign w_alu_stay = r_alu_v && !w_grant_alu;
    assign w_mem_stay = r_mem_v && !w_grant_mem;

    always_comb begin
        we3 = 1'b0;
        ad3 = '0;
        wd3 = '0;
        if (!rst) begin
            if (w_grant_alu) begin
                we3 = 1'b1;
                ad3 = r_alu_addr;
                wd3 = r_alu_data;
            end else if (w_grant_mem) begin
                we3 = 1'b1;
                ad3 = r_mem_addr;
                wd3 = r_mem_data;
`ifdef WB_BYPASS_EN
            end else if (w_byp_alu) begin
                we3 = 1'b1;
                ad3 = alu_addr;
                wd3 = alu_data;
            end else if (w_byp_mem) begin
                we3 = 1'b1;
                ad3 = mem_addr;
                wd3 = mem_data;
`endif
            end
        end
    end

    always_comb begin
        w_busy = '0;
        if (r_alu_v) w_busy[r_alu_addr] = 1'b1;
        if (r_mem_v) w_busy[r_mem_addr] = 1'b1;
        w_busy[0] = 1'b0;
    end

    assign busy         = rst ? '0 : w_busy;
    assign conflict_cnt = r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_v        <= 1'b0;
            r_alu_addr     <= '0;
            r_alu_data     <= '0;
            r_mem_v        <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_data     <= '0;
            r_rr           <= 1'b0;
            r_age          <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_alu_load) begin
                r_alu_v    <= 1'b1;
                r_alu_addr <= alu_addr;
                r_alu_data <= alu_data;
            end else if (w_grant_alu) begin
                r_alu_v    <= 1'b0;
            end

            if (w_mem_load) begin
                r_mem_v    <= 1'b1;
                r_mem_addr <= mem_addr;
                r_mem_data <= mem_data;
            end else if (w_grant_mem) begin
                r_mem_v    <= 1'b0;
            end

            if (w_contended) r_rr <= !r_rr;

            // A fresh load is younger than a held entry; simultaneous loads treat mem as older.
            if (w_alu_load && (w_mem_load || w_mem_stay)) begin
                r_age <= 1'b1;
            end else if (w_mem_load && w_alu_stay) begin
                r_age <= 1'b0;
            end

            if (w_both && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Self-checking bench for regfile_wb_arbiter; expected writes are
//             queued in issue order and compared as the write port fires.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic              clk;
    logic              rst;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              we3;
    logic [ADDR_W-1:0] ad3;
    logic [DATA_W-1:0] wd3;
    logic [NREG-1:0]   busy;
    logic [15:0]       conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0]        shadow[NREG];

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .we3          (we3),
        .ad3          (ad3),
        .wd3          (wd3),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write on the port must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (we3 === 1'b1) begin
            wr_cnt++;
            shadow[ad3] = wd3;
            if (exp_q.size() == 0) check("unexpected_wr", {ad3, wd3}, 64'h0);
            else                   check("wr_order", {ad3, wd3}, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            step();
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [ADDR_W+DATA_W-1:0] t5_alu(input int n);
        return {ADDR_W'(10 + n % 5), DATA_W'(32'hA000_0000 + n)};
    endfunction

    function automatic logic [ADDR_W+DATA_W-1:0] t5_mem(input int n);
        return {ADDR_W'(20 + n % 5), DATA_W'(32'hB000_0000 + n)};
    endfunction

    initial begin
        int a_n, m_n, wr_base;
        logic a_go, m_go;
        logic [ADDR_W+DATA_W-1:0] item;

        alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
        for (int i = 0; i < NREG; i++) shadow[i] = '0;

        // Reset state and a lone ALU request
        do_reset(3);
        @(negedge clk);
        check("rst_we3", we3, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", conflict_cnt, 0);
        step();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clk);
        check("t1_alu_ready", alu_ready, 1);
`ifdef WB_BYPASS_EN
        check("t1_byp_we3", we3, 1);
        check("t1_byp_ad3", ad3, 5);
        check("t1_byp_busy", busy, 0);
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        check("t1_idle_we3", we3, 0);
`else
        check("t1_no_early_we3", we3, 0);
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        check("t1_we3", we3, 1);
        check("t1_ad3", ad3, 5);
        check("t1_wd3", wd3, 32'hDEADBEEF);
        check("t1_busy", busy, 32'h20);
        step();
        @(negedge clk);
        check("t1_idle_we3", we3, 0);
        check("t1_idle_busy", busy, 0);
`endif

        // Zero-register requests are accepted and dropped
        step();
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h1234;
        @(negedge clk);
        check("t2_ready", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_we3", we3, 0);
            check("t2_busy", busy, 0);
            check("t2_ad3", ad3, 0);
            step();
        end

        // Contention on different registers: rr starts at ALU
        do_reset(2);
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h77;
        exp_q.push_back({5'd3, 32'h33});
        exp_q.push_back({5'd7, 32'h77});
        @(negedge clk);
        check("t3_readies", {alu_ready, mem_ready}, 2'b11);
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        check("t3_c1_ad3", ad3, 3);
        check("t3_c1_busy", busy, 32'h88);
        step();
        @(negedge clk);
        check("t3_c2_ad3", ad3, 7);
        step();
        @(negedge clk);
        check("t3_cnt", conflict_cnt, 1);
        check("t3_idle", we3, 0);
        drain();

        // Same-address pair loaded together: mem is older
        do_reset(2);
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'hAAAA0001;
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'hBBBB0002;
        exp_q.push_back({5'd9, 32'hAAAA0001});
        exp_q.push_back({5'd9, 32'hBBBB0002});
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        check("t4a_first", wd3, 32'hAAAA0001);
        step();
        @(negedge clk);
        check("t4a_second", wd3, 32'hBBBB0002);
        step();
        check("t4a_final", shadow[9], 32'hBBBB0002);
        drain();

        // ALU entry for r9 held by contention, mem r9 arrives later
        do_reset(2);
        alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h1111;
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h2222;
        exp_q.push_back({5'd2, 32'h1111});
        exp_q.push_back({5'd4, 32'h2222});
        exp_q.push_back({5'd9, 32'hC0C0});
        exp_q.push_back({5'd9, 32'hD0D0});
        step();
        alu_addr = 5'd9; alu_data = 32'hC0C0; mem_valid = 1'b0;
        @(negedge clk);
        check("t4b_c1_ad3", ad3, 2);
        check("t4b_c1_ready", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'hD0D0;
        @(negedge clk);
        check("t4b_c2_ad3", ad3, 4);
        check("t4b_c2_ready", mem_ready, 1);
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        check("t4b_c3_wd3", wd3, 32'hC0C0);
        step();
        @(negedge clk);
        check("t4b_c4_wd3", wd3, 32'hD0D0);
        step();
        check("t4b_final", shadow[9], 32'hD0D0);
        drain();

        // Sustained backpressure: writes alternate ALU, mem, ALU ...
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(t5_alu(i));
            if (i < 5) exp_q.push_back(t5_mem(i));
        end
        a_n = 0; m_n = 0; wr_base = wr_cnt;
        alu_valid = 1'b1; mem_valid = 1'b1;
        item = t5_alu(0); {alu_addr, alu_data} = item;
        item = t5_mem(0); {mem_addr, mem_data} = item;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                check("t5_we3", we3, 1);
                check("t5_alu_ready", alu_ready, (k % 2 == 1));
                check("t5_one_ready", alu_ready ^ mem_ready, 1);
            end
            a_go = alu_ready; m_go = mem_ready;
            step();
            if (a_go) begin a_n++; item = t5_alu(a_n); {alu_addr, alu_data} = item; end
            if (m_go) begin m_n++; item = t5_mem(m_n); {mem_addr, mem_data} = item; end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        drain();
        check("t5_alu_xfers", a_n, 6);
        check("t5_mem_xfers", m_n, 5);
        check("t5_writes", wr_cnt - wr_base, 11);
        check("t5_cnt_range", (conflict_cnt >= 16'd9) && (conflict_cnt <= 16'd10), 1);

        // Reset while both slots hold writes: nothing is written
        do_reset(2);
        alu_valid = 1'b1; alu_addr = 5'd11; alu_data = 32'h5555;
        mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'h6666;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_we3", we3, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", {alu_ready, mem_ready}, 2'b00);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_post_we3", we3, 0);
            check("t6_post_busy", busy, 0);
            check("t6_post_ready", {alu_ready, mem_ready}, 2'b11);
            step();
        end
        check("t6_cnt", conflict_cnt, 0);

`ifdef WB_BYPASS_EN
        alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h7777;
        exp_q.push_back({5'd6, 32'h7777});
        @(negedge clk);
        check("t6_byp_we3", we3, 1);
        check("t6_byp_ad3", ad3, 6);
        check("t6_byp_busy", busy, 0);
        step();
        alu_valid = 1'b0;
        drain();
`endif

        check("final_queue", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
